// File: rtl/instruction_loader_pkg.sv
// Constants and state encoding shared by the instruction loader and the decode/control logic.
package instruction_loader_pkg;

   localparam int unsigned INSTR_MEM_ADDR_WIDTH = 8;

   localparam logic [5:0]  HALT_OPCODE = 6'b111111;
   localparam logic [31:0] HALT_WORD   = {HALT_OPCODE, 26'd0};

   localparam logic [1:0] LD_IDLE  = 2'd0;
   localparam logic [1:0] LD_LOAD  = 2'd1;
   localparam logic [1:0] LD_DONE  = 2'd2;
   localparam logic [1:0] LD_ERROR = 2'd3;

   typedef enum logic [1:0] {
      StIdle  = LD_IDLE,
      StLoad  = LD_LOAD,
      StDone  = LD_DONE,
      StError = LD_ERROR
   } ld_state_e;

endpackage

// File: rtl/instruction_loader_timeout_counter.sv
// Inter-byte watchdog: a loadable down-counter that flags expiry once armed by a load.
module loader_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] START = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;
   logic          armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         armed <= 1'b0;
      end else if (clear) begin
         count <= '0;
         armed <= 1'b0;
      end else if (load) begin
         count <= START;
         armed <= 1'b1;
      end else if (enable && armed && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   // Unarmed means no byte yet in this load, so the watchdog must stay quiet.
   assign expired = armed && (count == '0);

endmodule

// File: rtl/instruction_loader.sv
// Streams UART program bytes into the byte-wide instruction memory, holding fetch halted
// until the HALT word arrives, memory overflows, or the byte stream stalls.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = INSTR_MEM_ADDR_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [31:0] HALT_WORD      = instruction_loader_pkg::HALT_WORD
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_start,
   input  logic [7:0]                i_rx_data,
   input  logic                      i_rx_valid,
   output logic                      o_write_instruction_mem,
   output logic [31:0]               o_instruction_mem_addr,
   output logic [31:0]               o_instruction_mem_data,
   output logic                      o_halt,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_error,
   output logic [MEM_ADDR_WIDTH-2:0] o_instr_count
);

   localparam int unsigned AW = MEM_ADDR_WIDTH;
   localparam int unsigned CW = MEM_ADDR_WIDTH - 1;

   ld_state_e     state;
   logic [AW:0]   addr;  // top bit set means every byte of memory has been written
   logic [1:0]    byte_idx;
   logic [23:0]   word_sr;
   logic          halt_pending;
   logic          in_load;
   logic          tmr_clear;
   logic          tmr_load;
   logic          tmr_expired;

   assign in_load   = (state == StLoad);
   assign tmr_clear = !in_load;
   assign tmr_load  = in_load && i_rx_valid;

   loader_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (i_clk),
      .rst_n  (i_reset),
      .clear  (tmr_clear),
      .load   (tmr_load),
      .enable (in_load),
      .expired(tmr_expired)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state                   <= StIdle;
         addr                    <= '0;
         byte_idx                <= '0;
         word_sr                 <= '0;
         halt_pending            <= 1'b0;
         o_write_instruction_mem <= 1'b0;
         o_instruction_mem_addr  <= '0;
         o_instruction_mem_data  <= '0;
         o_halt                  <= 1'b0;
         o_busy                  <= 1'b0;
         o_done                  <= 1'b0;
         o_error                 <= 1'b0;
         o_instr_count           <= '0;
      end else begin
         o_write_instruction_mem <= 1'b0;
         case (state)
            StLoad: begin
               // HALT completes one cycle after its last byte's write, so that write
               // is still seen with fetch halted.
               if (halt_pending) begin
                  state        <= StDone;
                  halt_pending <= 1'b0;
                  o_done       <= 1'b1;
                  o_halt       <= 1'b0;
                  o_busy       <= 1'b0;
               end else if (i_rx_valid) begin
                  if (addr[AW]) begin
                     state   <= StError;
                     o_error <= 1'b1;
                     o_halt  <= 1'b0;
                     o_busy  <= 1'b0;
                  end else begin
                     o_write_instruction_mem <= 1'b1;
                     o_instruction_mem_addr  <= 32'(addr);
                     o_instruction_mem_data  <= {24'd0, i_rx_data};
                     addr                    <= addr + (AW + 1)'(1);
                     byte_idx                <= byte_idx + 2'd1;
                     word_sr                 <= {word_sr[15:0], i_rx_data};
                     if (byte_idx == 2'd3) begin
                        o_instr_count <= o_instr_count + CW'(1);
                        if ({word_sr, i_rx_data} == HALT_WORD) begin
                           halt_pending <= 1'b1;
                        end
                     end
                  end
               end else if (tmr_expired) begin
                  state   <= StError;
                  o_error <= 1'b1;
                  o_halt  <= 1'b0;
                  o_busy  <= 1'b0;
               end
            end
            StIdle, StDone, StError: begin
               if (i_start) begin
                  state         <= StLoad;
                  addr          <= '0;
                  byte_idx      <= '0;
                  word_sr       <= '0;
                  halt_pending  <= 1'b0;
                  o_instr_count <= '0;
                  o_done        <= 1'b0;
                  o_error       <= 1'b0;
                  o_halt        <= 1'b1;
                  o_busy        <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
